// File: rtl/collision_scanner.sv
// collision_scanner: once per frame, scans every enemy slot one per clock
// against the player position. It reports the lowest overlapping enabled slot,
// and it keeps track of lives, post-hit grace frames and game-over.
// Optional build macro: HITBOX_CIRCLE_EN selects a circular hitbox instead of
// the per-axis box.
module collision_scanner #(
    parameter int ENEMIES      = 27,
    parameter int COORD_W      = 10,
    parameter int HIT_RADIUS   = 9,
    parameter int LIVES        = 3,
    parameter int GRACE_FRAMES = 30,
    localparam int IDX_W       = (ENEMIES > 1) ? $clog2(ENEMIES) : 1,
    localparam int LIVES_W     = (LIVES > 0) ? $clog2(LIVES + 1) : 1
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       Frame_tick,
    input  logic                       Clear,
    input  logic [COORD_W-1:0]         BallX,
    input  logic [COORD_W-1:0]         BallY,
    input  logic [ENEMIES*COORD_W-1:0] EnemyX,
    input  logic [ENEMIES*COORD_W-1:0] EnemyY,
    input  logic [ENEMIES-1:0]         Enable,
    output logic                       Busy,
    output logic                       Hit,
    output logic [IDX_W-1:0]           Hit_index,
    output logic                       Player_reset,
    output logic [LIVES_W-1:0]         Lives,
    output logic                       Game_over,
    output logic                       Overrun
);

    localparam int GRACE_W = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
    localparam int DIFF_W  = COORD_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENEMIES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     match_q, match_d;
    logic                 found_q, found_d;
    logic [COORD_W-1:0]   ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic [IDX_W-1:0]     hit_index_q, hit_index_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic [GRACE_W-1:0]   grace_q, grace_d;
    logic                 game_over_q, game_over_d;
    logic                 overrun_q, overrun_d;

    // Unpacked per-slot views of the packed enemy buses.
    logic [COORD_W-1:0] enemy_x [ENEMIES];
    logic [COORD_W-1:0] enemy_y [ENEMIES];
    generate
        for (genvar gi = 0; gi < ENEMIES; gi++) begin : g_slot
            assign enemy_x[gi] = EnemyX[gi*COORD_W +: COORD_W];
            assign enemy_y[gi] = EnemyY[gi*COORD_W +: COORD_W];
        end
    endgenerate

    // Absolute per-axis distance of the slot under scan. The extra bit keeps
    // the subtraction from wrapping across the screen edge.
    logic [COORD_W-1:0] cur_x, cur_y;
    logic [DIFF_W-1:0]  dx, dy;
    logic               overlap;

    assign cur_x = enemy_x[idx_q];
    assign cur_y = enemy_y[idx_q];
    assign dx = (ball_x_q >= cur_x) ? ({1'b0, ball_x_q} - {1'b0, cur_x})
                                    : ({1'b0, cur_x} - {1'b0, ball_x_q});
    assign dy = (ball_y_q >= cur_y) ? ({1'b0, ball_y_q} - {1'b0, cur_y})
                                    : ({1'b0, cur_y} - {1'b0, ball_y_q});

`ifdef HITBOX_CIRCLE_EN
    localparam int SQ_W = 2 * DIFF_W;
    logic [SQ_W-1:0] dx_sq, dy_sq;
    logic [SQ_W:0]   dist_sq;
    assign dx_sq   = SQ_W'(dx) * SQ_W'(dx);
    assign dy_sq   = SQ_W'(dy) * SQ_W'(dy);
    assign dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};
    assign overlap = dist_sq <= (SQ_W + 1)'(HIT_RADIUS * HIT_RADIUS);
`else
    assign overlap = (dx <= DIFF_W'(HIT_RADIUS)) && (dy <= DIFF_W'(HIT_RADIUS));
`endif

    // A hit counts only outside grace, before game-over, and when no Clear
    // competes for the same cycle.
    logic counted;
    assign counted = (state_q == REPORT) && found_q && (grace_q == '0) &&
                     !game_over_q && !Clear;

    assign Busy         = (state_q != IDLE);
    assign Hit          = counted;
    assign Player_reset = counted;
    assign Hit_index    = counted ? match_q : hit_index_q;
    assign Lives        = lives_q;
    assign Game_over    = game_over_q;
    assign Overrun      = overrun_q;

    // Next-state logic: scan sequencing, first-match latch, lives/grace book-keeping.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        match_d     = match_q;
        found_d     = found_q;
        ball_x_d    = ball_x_q;
        ball_y_d    = ball_y_q;
        hit_index_d = hit_index_q;
        lives_d     = lives_q;
        grace_d     = grace_q;
        game_over_d = game_over_q;
        overrun_d   = overrun_q;

        case (state_q)
            IDLE: begin
                if (Frame_tick) begin
                    ball_x_d = BallX;
                    ball_y_d = BallY;
                    idx_d    = '0;
                    found_d  = 1'b0;
                    state_d  = SCAN;
                    if (grace_q != '0) grace_d = grace_q - 1'b1;
                end
            end
            SCAN: begin
                if (Enable[idx_q] && overlap && !found_q) begin
                    found_d = 1'b1;
                    match_d = idx_q;
                end
                if (idx_q == LAST_IDX) state_d = REPORT;
                else                   idx_d   = idx_q + 1'b1;
            end
            REPORT: begin
                state_d = IDLE;
                if (counted) begin
                    hit_index_d = match_q;
                    lives_d     = lives_q - 1'b1;
                    grace_d     = GRACE_W'(GRACE_FRAMES);
                    if (lives_q == LIVES_W'(1)) game_over_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A tick that lands mid-scan is dropped and flagged.
        if (Frame_tick && (state_q != IDLE)) overrun_d = 1'b1;

        if (Clear) begin
            lives_d     = LIVES_W'(LIVES);
            game_over_d = 1'b0;
            overrun_d   = 1'b0;
            grace_d     = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            match_q     <= '0;
            found_q     <= 1'b0;
            ball_x_q    <= '0;
            ball_y_q    <= '0;
            hit_index_q <= '0;
            lives_q     <= LIVES_W'(LIVES);
            grace_q     <= '0;
            game_over_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            match_q     <= match_d;
            found_q     <= found_d;
            ball_x_q    <= ball_x_d;
            ball_y_q    <= ball_y_d;
            hit_index_q <= hit_index_d;
            lives_q     <= lives_d;
            grace_q     <= grace_d;
            game_over_q <= game_over_d;
            overrun_q   <= overrun_d;
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Testbench for collision_scanner: a directed vector table plus hand-written
// sequences for grace, game-over, overrun and mid-scan reset.
module tb_collision_scanner;

    localparam int E = 27;
    localparam int W = 10;
`ifdef HITBOX_CIRCLE_EN
    localparam int CIRC = 1;
`else
    localparam int CIRC = 0;
`endif

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           Frame_tick;
    logic           Clear;
    logic [W-1:0]   BallX, BallY;
    logic [E*W-1:0] EnemyX, EnemyY;
    logic [E-1:0]   Enable;
    logic           Busy, Hit, Player_reset, Game_over, Overrun;
    logic [4:0]     Hit_index;
    logic [1:0]     Lives;

    collision_scanner #(
        .ENEMIES(E), .COORD_W(W), .HIT_RADIUS(9), .LIVES(3), .GRACE_FRAMES(30)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Frame_tick(Frame_tick), .Clear(Clear),
        .BallX(BallX), .BallY(BallY), .EnemyX(EnemyX), .EnemyY(EnemyY),
        .Enable(Enable), .Busy(Busy), .Hit(Hit), .Hit_index(Hit_index),
        .Player_reset(Player_reset), .Lives(Lives), .Game_over(Game_over),
        .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Park every slot far away and disabled.
    task automatic clear_enemies();
        for (int i = 0; i < E; i++) begin
            EnemyX[i*W +: W] = 10'd1000;
            EnemyY[i*W +: W] = 10'd1000;
        end
        Enable = '0;
    endtask

    task automatic set_slot(input int s, input int x, input int y, input int en);
        EnemyX[s*W +: W] = W'(x);
        EnemyY[s*W +: W] = W'(y);
        Enable[s]        = en[0];
    endtask

    task automatic pulse_clear();
        @(negedge Clk); Clear = 1'b1;
        @(negedge Clk); Clear = 1'b0;
    endtask

    // One frame: tick, then watch E+2 cycles. n counts cycles after the tick cycle.
    task automatic run_frame(output int hits, output int first_n, output int idx_at,
                             output int pr_at, output int busy_err);
        hits = 0; first_n = -1; idx_at = -1; pr_at = -1; busy_err = 0;
        @(negedge Clk); Frame_tick = 1'b1;
        @(negedge Clk); Frame_tick = 1'b0;
        for (int n = 1; n <= E + 2; n++) begin
            if (n > 1) @(negedge Clk);
            if (Hit) begin
                hits++;
                if (first_n < 0) begin
                    first_n = n;
                    idx_at  = int'(Hit_index);
                    pr_at   = int'(Player_reset);
                end
            end
            if (Busy !== (n <= E + 1)) busy_err++;
        end
    endtask

    typedef struct {
        int bx, by;
        int sa, xa, ya, ena;
        int sb, xb, yb, enb;
        int hit, idx;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int hits, first_n, idx_at, pr_at, busy_err, total, frames, busy_cnt;

        vecs[0] = '{100, 100,  5, 105, 108, 1, -1, 0, 0, 0, 1 - CIRC, 5};
        vecs[1] = '{100, 100,  3, 100, 100, 1,  7, 101, 99, 1, 1, 3};
        vecs[2] = '{1020, 50,  0,   3,  50, 1, -1, 0, 0, 0, 0, 0};
        vecs[3] = '{  9,  50,  0,   0,  50, 1, -1, 0, 0, 0, 1, 0};
        vecs[4] = '{100, 100, 10, 110, 100, 1, -1, 0, 0, 0, 0, 0};
        vecs[5] = '{100, 100, 26,  91, 109, 1, -1, 0, 0, 0, 1 - CIRC, 26};
        vecs[6] = '{100, 100,  4, 100, 100, 0, -1, 0, 0, 0, 0, 0};
        vecs[7] = '{  0,   0,  1,   9,   0, 1, -1, 0, 0, 0, 1, 1};
        vecs[8] = '{100, 100,  2, 107, 107, 1, -1, 0, 0, 0, 1 - CIRC, 2};
        vecs[9] = '{100, 100, 13, 106, 106, 1, -1, 0, 0, 0, 1, 13};

        Reset_n = 1'b0; Frame_tick = 1'b0; Clear = 1'b0;
        BallX = '0; BallY = '0;
        clear_enemies();
        repeat (3) @(negedge Clk);

        // Reset state.
        chk("rst_busy", int'(Busy), 0);
        chk("rst_hit", int'(Hit), 0);
        chk("rst_hit_index", int'(Hit_index), 0);
        chk("rst_player_reset", int'(Player_reset), 0);
        chk("rst_lives", int'(Lives), 3);
        chk("rst_game_over", int'(Game_over), 0);
        chk("rst_overrun", int'(Overrun), 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Table-driven single-frame vectors, each from a fresh Clear.
        for (int v = 0; v < 10; v++) begin
            pulse_clear();
            clear_enemies();
            BallX = W'(vecs[v].bx); BallY = W'(vecs[v].by);
            set_slot(vecs[v].sa, vecs[v].xa, vecs[v].ya, vecs[v].ena);
            if (vecs[v].sb >= 0) set_slot(vecs[v].sb, vecs[v].xb, vecs[v].yb, vecs[v].enb);
            run_frame(hits, first_n, idx_at, pr_at, busy_err);
            $display("vec %0d: ball=(%0d,%0d) hits=%0d n=%0d idx=%0d lives=%0d",
                     v, vecs[v].bx, vecs[v].by, hits, first_n, idx_at, Lives);
            chk($sformatf("vec%0d_hits", v), hits, vecs[v].hit);
            chk($sformatf("vec%0d_busy", v), busy_err, 0);
            chk($sformatf("vec%0d_lives", v), int'(Lives), 3 - vecs[v].hit);
            if (vecs[v].hit == 1) begin
                chk($sformatf("vec%0d_latency", v), first_n, E + 1);
                chk($sformatf("vec%0d_index", v), idx_at, vecs[v].idx);
                chk($sformatf("vec%0d_player_reset", v), pr_at, 1);
                chk($sformatf("vec%0d_index_held", v), int'(Hit_index), vecs[v].idx);
            end
        end

        // Wrap-around: no hit across 5 frames.
        pulse_clear(); clear_enemies();
        BallX = 10'd1020; BallY = 10'd50; set_slot(0, 3, 50, 1);
        total = 0;
        for (int f = 0; f < 5; f++) begin
            run_frame(hits, first_n, idx_at, pr_at, busy_err);
            total += hits;
        end
        $display("wrap: hits over 5 frames=%0d", total);
        chk("wrap_5_frames", total, 0);

        // Overrun: second tick 10 cycles into the scan is dropped.
        pulse_clear(); clear_enemies();
        BallX = 10'd100; BallY = 10'd100; set_slot(5, 103, 104, 1);
        total = 0; busy_cnt = 0;
        @(negedge Clk); Frame_tick = 1'b1;
        @(negedge Clk); Frame_tick = 1'b0;
        for (int n = 1; n <= 70; n++) begin
            if (n > 1) @(negedge Clk);
            if (n == 10) Frame_tick = 1'b1;
            if (n == 11) Frame_tick = 1'b0;
            if (Hit) total++;
            if (Busy) busy_cnt++;
        end
        $display("overrun: hits=%0d busy_cycles=%0d overrun=%0d", total, busy_cnt, Overrun);
        chk("overrun_flag", int'(Overrun), 1);
        chk("overrun_one_report", total, 1);
        chk("overrun_busy_cycles", busy_cnt, E + 1);
        chk("overrun_lives", int'(Lives), 2);

        // Reset mid-scan (cycle 12): everything returns to reset values, no Hit.
        set_slot(5, 100, 100, 1);
        total = 0;
        @(negedge Clk); Frame_tick = 1'b1;
        @(negedge Clk); Frame_tick = 1'b0;
        repeat (11) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        $display("midscan reset: busy=%0d lives=%0d overrun=%0d idx=%0d", Busy, Lives, Overrun, Hit_index);
        chk("midrst_busy", int'(Busy), 0);
        chk("midrst_hit", int'(Hit), 0);
        chk("midrst_player_reset", int'(Player_reset), 0);
        chk("midrst_hit_index", int'(Hit_index), 0);
        chk("midrst_lives", int'(Lives), 3);
        chk("midrst_game_over", int'(Game_over), 0);
        chk("midrst_overrun", int'(Overrun), 0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (Hit) total++;
        end
        chk("midrst_no_hit", total, 0);

        // Grace window: 29 ignored frames, hit on the 30th.
        run_frame(hits, first_n, idx_at, pr_at, busy_err);
        chk("grace_first_hit", hits, 1);
        chk("grace_lives_2", int'(Lives), 2);
        total = 0;
        for (int f = 0; f < 29; f++) begin
            run_frame(hits, first_n, idx_at, pr_at, busy_err);
            total += hits;
        end
        $display("grace: hits in 29 grace frames=%0d lives=%0d", total, Lives);
        chk("grace_suppressed", total, 0);
        chk("grace_lives_held", int'(Lives), 2);
        run_frame(hits, first_n, idx_at, pr_at, busy_err);
        $display("grace: frame 30 hits=%0d lives=%0d", hits, Lives);
        chk("grace_expired_hit", hits, 1);
        chk("grace_lives_1", int'(Lives), 1);

        // Game over after three counted hits, then frozen, then Clear.
        pulse_clear();
        total = 0; frames = 0;
        while (total < 3 && frames < 100) begin
            run_frame(hits, first_n, idx_at, pr_at, busy_err);
            total += hits; frames++;
        end
        $display("game over: frames=%0d lives=%0d game_over=%0d", frames, Lives, Game_over);
        chk("gameover_frames", frames, 61);
        chk("gameover_lives", int'(Lives), 0);
        chk("gameover_flag", int'(Game_over), 1);
        total = 0;
        for (int f = 0; f < 35; f++) begin
            run_frame(hits, first_n, idx_at, pr_at, busy_err);
            total += hits;
        end
        chk("gameover_frozen_hits", total, 0);
        chk("gameover_frozen_lives", int'(Lives), 0);
        pulse_clear();
        @(negedge Clk);
        $display("clear: lives=%0d game_over=%0d", Lives, Game_over);
        chk("clear_lives", int'(Lives), 3);
        chk("clear_game_over", int'(Game_over), 0);

        // Enable toggling between frames.
        clear_enemies();
        BallX = 10'd100; BallY = 10'd100; set_slot(8, 102, 98, 0);
        run_frame(hits, first_n, idx_at, pr_at, busy_err);
        chk("enable_off_no_hit", hits, 0);
        Enable[8] = 1'b1;
        run_frame(hits, first_n, idx_at, pr_at, busy_err);
        $display("enable toggle: hits=%0d idx=%0d", hits, idx_at);
        chk("enable_on_hit", hits, 1);
        chk("enable_on_index", idx_at, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
